// File: rtl/secuenciador_pkg.sv
// Shared definitions for the Micro UAZ program sequencer: opcodes, jump
// conditions, FSM states and the jump-condition evaluator.
package secuenciador_pkg;

    localparam logic [3:0] OP_NOP     = 4'h0;
    localparam logic [3:0] OP_ALU_MIN = 4'h1;
    localparam logic [3:0] OP_ALU_MAX = 4'h7;
    localparam logic [3:0] OP_JMP     = 4'h8;
    localparam logic [3:0] OP_CALL    = 4'h9;
    localparam logic [3:0] OP_RET     = 4'hA;
    localparam logic [3:0] OP_HALT    = 4'hF;

    localparam logic [2:0] COND_SIEMPRE   = 3'b000;
    localparam logic [2:0] COND_SIEMPRE_B = 3'b001;
    localparam logic [2:0] COND_Z         = 3'b010;
    localparam logic [2:0] COND_NZ        = 3'b011;
    localparam logic [2:0] COND_C         = 3'b100;
    localparam logic [2:0] COND_NC        = 3'b101;
    localparam logic [2:0] COND_N         = 3'b110;
    localparam logic [2:0] COND_NN        = 3'b111;

    localparam int BAND_Z = 0;
    localparam int BAND_C = 1;
    localparam int BAND_N = 2;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALT
    } estado_t;

    function automatic logic es_op_alu(input logic [3:0] op);
        return (op >= OP_ALU_MIN) && (op <= OP_ALU_MAX);
    endfunction

    function automatic logic condicion_cumplida(input logic [2:0] cond,
                                                input logic [2:0] banderas);
        logic r;
        case (cond)
            COND_Z:  r = banderas[BAND_Z];
            COND_NZ: r = ~banderas[BAND_Z];
            COND_C:  r = banderas[BAND_C];
            COND_NC: r = ~banderas[BAND_C];
            COND_N:  r = banderas[BAND_N];
            COND_NN: r = ~banderas[BAND_N];
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/secuenciador_de_programa_pila.sv
// Return-address LIFO for CALL/RET. The top entry is readable combinationally
// so RET can load the PC on the same edge that pops it.
module pila_de_retorno #(
    parameter int PROFUNDIDAD_PILA = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] dato_in,
    output logic [7:0] dato_out,
    output logic       llena,
    output logic       vacia
);
    localparam int AW = $clog2(PROFUNDIDAD_PILA);
    localparam logic [AW:0]   PTR_UNO   = 1;
    localparam logic [AW-1:0] IDX_UNO   = 1;
    localparam logic [AW:0]   PTR_LLENO = (AW+1)'(PROFUNDIDAD_PILA);

    logic [7:0]    r_mem [PROFUNDIDAD_PILA];
    logic [AW:0]   r_ptr;
    logic [AW-1:0] w_idx_tope;

    assign llena      = (r_ptr == PTR_LLENO);
    assign vacia      = (r_ptr == '0);
    assign w_idx_tope = r_ptr[AW-1:0] - IDX_UNO;
    assign dato_out   = r_mem[w_idx_tope];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ptr <= '0;
        end else if (push && !llena) begin
            r_ptr <= r_ptr + PTR_UNO;
        end else if (pop && !vacia) begin
            r_ptr <= r_ptr - PTR_UNO;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PROFUNDIDAD_PILA; gi++) begin : g_entrada
            always_ff @(posedge Clk) begin
                if (push && !llena && (r_ptr[AW-1:0] == AW'(gi))) begin
                    r_mem[gi] <= dato_in;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/secuenciador_de_programa.sv
// Micro UAZ program sequencer: fetch/decode/execute FSM, PC, IR, conditional
// jumps on ALU flags, CALL/RET through the return stack and ALU execute strobe.
module secuenciador_de_programa
    import secuenciador_pkg::*;
#(
    parameter int PROFUNDIDAD_PILA = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] i_Instruccion,
    input  logic        i_Instruccion_Valida,
    input  logic [2:0]  Banderas,
    output logic [7:0]  o_Bus_Direcciones_Instrucciones,
    output logic        o_Leer_Instruccion,
    output logic        o_Ejecutar,
    output logic [3:0]  o_Opcode,
    output logic [7:0]  o_Operando,
    output logic        o_Detenido,
    output logic        o_Error_Pila
);
    estado_t     r_estado, w_estado_next;
    logic [7:0]  r_pc, w_pc_next;
    logic [15:0] r_ir;
    logic        r_ejecutar;
    logic [3:0]  r_opcode;
    logic [7:0]  r_operando;
    logic        r_detenido;
    logic        r_error_pila;

    logic        w_push, w_pop, w_error_pila, w_entra_execute;
    logic        w_llena, w_vacia;
    logic [7:0]  w_pila_out;
    logic [3:0]  w_op;
    logic [2:0]  w_cond;
    logic [7:0]  w_dir;
    logic        w_unused_ir;

    assign w_op   = r_ir[15:12];
    assign w_cond = r_ir[10:8];
    assign w_dir  = r_ir[7:0];
    // IR[11] is a reserved bit of the instruction format.
    assign w_unused_ir = r_ir[11];

    pila_de_retorno #(
        .PROFUNDIDAD_PILA(PROFUNDIDAD_PILA)
    ) u_pila (
        .Clk      (Clk),
        .Rst      (Rst),
        .push     (w_push),
        .pop      (w_pop),
        .dato_in  (r_pc + 8'd1),
        .dato_out (w_pila_out),
        .llena    (w_llena),
        .vacia    (w_vacia)
    );

    always_comb begin
        w_estado_next = r_estado;
        w_pc_next     = r_pc;
        w_push        = 1'b0;
        w_pop         = 1'b0;
        w_error_pila  = 1'b0;
        case (r_estado)
            ST_FETCH: begin
                if (i_Instruccion_Valida) w_estado_next = ST_DECODE;
            end
            ST_DECODE: begin
                if ((w_op == OP_CALL && w_llena) || (w_op == OP_RET && w_vacia)) begin
                    w_estado_next = ST_HALT;
                    w_error_pila  = 1'b1;
                end else begin
                    w_estado_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                w_estado_next = ST_FETCH;
                w_pc_next     = r_pc + 8'd1;
                case (w_op)
                    OP_JMP: if (condicion_cumplida(w_cond, Banderas)) w_pc_next = w_dir;
                    OP_CALL: begin
                        w_push    = 1'b1;
                        w_pc_next = w_dir;
                    end
                    OP_RET: begin
                        w_pop     = 1'b1;
                        w_pc_next = w_pila_out;
                    end
                    OP_HALT: begin
                        w_estado_next = ST_HALT;
                        w_pc_next     = r_pc;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign w_entra_execute = (r_estado == ST_DECODE) && (w_estado_next == ST_EXECUTE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_estado     <= ST_FETCH;
            r_pc         <= 8'h00;
            r_ir         <= 16'h0000;
            r_ejecutar   <= 1'b0;
            r_opcode     <= 4'h0;
            r_operando   <= 8'h00;
            r_detenido   <= 1'b0;
            r_error_pila <= 1'b0;
        end else begin
            r_estado   <= w_estado_next;
            r_pc       <= w_pc_next;
            if (r_estado == ST_FETCH && i_Instruccion_Valida) r_ir <= i_Instruccion;
            // Opcode/operand only change when a strobe is issued, so they hold otherwise.
            r_ejecutar <= w_entra_execute && es_op_alu(w_op);
            if (w_entra_execute && es_op_alu(w_op)) begin
                r_opcode   <= w_op;
                r_operando <= w_dir;
            end
            if (w_error_pila) begin
                r_error_pila <= 1'b1;
                r_detenido   <= 1'b1;
            end
            if (r_estado == ST_EXECUTE && w_op == OP_HALT) r_detenido <= 1'b1;
        end
    end

    assign o_Bus_Direcciones_Instrucciones = r_pc;
    assign o_Leer_Instruccion              = (r_estado == ST_FETCH) && !Rst;
    assign o_Ejecutar                      = r_ejecutar;
    assign o_Opcode                        = r_opcode;
    assign o_Operando                      = r_operando;
    assign o_Detenido                      = r_detenido;
    assign o_Error_Pila                    = r_error_pila;

endmodule
